// File: rtl/dpu_pkg.sv
// Shared types, constants and FP32 rounding helper for the dot-product unit.
// Latency: n/a (package).
// Backpressure: n/a (package).
package dpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [31:0] FP32_ZERO  = 32'h0000_0000;
    localparam logic [31:0] FP32_QNAN  = 32'h7FC0_0000;
    localparam int          RD_LAT_MAX = 2;

    // Round-nearest-even and pack. m carries the hidden one at bit 26 and
    // guard/round/sticky in bits 2..0; e is the biased exponent for m[26].
    // Results below the normal range flush to signed zero, above saturate to inf.
    function automatic logic [31:0] fp32_pack(input logic s,
                                              input logic signed [11:0] e,
                                              input logic [26:0] m);
        logic               up;
        logic [24:0]        r;
        logic signed [11:0] ee;
        up = m[2] & (m[1] | m[0] | m[3]);
        r  = {1'b0, m[26:3]} + {24'b0, up};
        ee = e;
        if (r[24]) begin
            r  = r >> 1;
            ee = ee + 12'sd1;
        end
        if (m == 27'd0 || ee <= 12'sd0) return {s, 31'b0};
        if (ee >= 12'sd255)             return {s, 8'hFF, 23'b0};
        return {s, ee[7:0], r[22:0]};
    endfunction

endpackage

// File: rtl/dot_product_unit_mac.sv
// Combinational FP32 multiply-add y = round(round(a*b) + c), not fused, RNE.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows inputs.
module fp32_mac
    import dpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    output logic [31:0] y
);

    function automatic logic [31:0] fp32_mul(input logic [31:0] x, input logic [31:0] z);
        logic               s, x_nan, z_nan, x_inf, z_inf, x_zero, z_zero;
        logic [47:0]        prod;
        logic signed [11:0] e;
        logic [26:0]        m;
        s      = x[31] ^ z[31];
        x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        z_nan  = (z[30:23] == 8'hFF) && (z[22:0] != 23'd0);
        x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        z_inf  = (z[30:23] == 8'hFF) && (z[22:0] == 23'd0);
        x_zero = (x[30:23] == 8'h00);
        z_zero = (z[30:23] == 8'h00);
        if (x_nan || z_nan || (x_inf && z_zero) || (z_inf && x_zero)) return FP32_QNAN;
        if (x_inf || z_inf)   return {s, 8'hFF, 23'b0};
        if (x_zero || z_zero) return {s, 31'b0};
        prod = 48'({1'b1, x[22:0]}) * 48'({1'b1, z[22:0]});
        e    = $signed({4'b0, x[30:23]}) + $signed({4'b0, z[30:23]}) - 12'sd127;
        if (prod[47]) begin
            m = {prod[47:22], |prod[21:0]};
            e = e + 12'sd1;
        end else begin
            m = {prod[46:21], |prod[20:0]};
        end
        return fp32_pack(s, e, m);
    endfunction

    function automatic logic [31:0] fp32_add(input logic [31:0] x, input logic [31:0] z);
        logic               x_nan, z_nan, x_inf, z_inf, x_zero, z_zero;
        logic [31:0]        big, sml;
        logic [7:0]         d;
        logic [26:0]        mb, al, m;
        logic [49:0]        sw;
        logic [27:0]        r;
        logic signed [11:0] e;
        x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        z_nan  = (z[30:23] == 8'hFF) && (z[22:0] != 23'd0);
        x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        z_inf  = (z[30:23] == 8'hFF) && (z[22:0] == 23'd0);
        x_zero = (x[30:23] == 8'h00);
        z_zero = (z[30:23] == 8'h00);
        if (x_nan || z_nan || (x_inf && z_inf && (x[31] != z[31]))) return FP32_QNAN;
        if (x_inf)             return {x[31], 8'hFF, 23'b0};
        if (z_inf)             return {z[31], 8'hFF, 23'b0};
        if (x_zero && z_zero)  return {x[31] & z[31], 31'b0};
        if (x_zero)            return z;
        if (z_zero)            return x;
        big = (x[30:0] >= z[30:0]) ? x : z;
        sml = (x[30:0] >= z[30:0]) ? z : x;
        d   = big[30:23] - sml[30:23];
        mb  = {1'b1, big[22:0], 3'b0};
        sw  = {1'b1, sml[22:0], 26'b0} >> d;
        al  = {sw[49:24], |sw[23:0]};
        e   = $signed({4'b0, big[30:23]});
        if (big[31] == sml[31]) begin
            r = {1'b0, mb} + {1'b0, al};
            if (r[27]) begin
                m = {r[27:2], |r[1:0]};
                e = e + 12'sd1;
            end else begin
                m = r[26:0];
            end
        end else begin
            m = mb - al;
            if (m == 27'd0) return FP32_ZERO;
            for (int i = 0; i < 27; i++) begin
                if (!m[26]) begin
                    m = m << 1;
                    e = e - 12'sd1;
                end
            end
        end
        return fp32_pack(big[31], e, m);
    endfunction

    // Product is rounded to FP32 before the accumulate add.
    always_comb begin
        y = fp32_add(fp32_mul(a, b), c);
    end

endmodule

// File: rtl/dot_product_unit.sv
// Walks k=0..len-1, multiplies patch[k]*filter[k] and accumulates in FP32.
// Latency: done in cycle len+RD_LAT+1 after the accepting edge (len=0: cycle 1).
// Backpressure: none; start ignored while busy, accepted again in the done cycle.
module dot_product_unit
    import dpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LAT     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] vec_length,
    input  logic [31:0]           patch_data,
    input  logic [31:0]           filter_data,
    output logic [ADDR_WIDTH-1:0] patch_addr,
    output logic [ADDR_WIDTH-1:0] filter_addr,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           result
);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   len, cnt;
    logic [RD_LAT_MAX:1]     tag_q;
    logic [RD_LAT_MAX:0]     tag;
    logic [31:0]             acc, acc_nxt, mac_out;
    logic                    issue, last, accept, tag_exit, tag_pend;

    assign issue       = (state == ISSUE);
    assign last        = (cnt == len - 1'b1);
    assign accept      = start && ((state == IDLE) || (state == FIN));
    assign tag         = {tag_q, issue};
    assign busy        = (state != IDLE);
    assign patch_addr  = issue ? cnt : '0;
    assign filter_addr = issue ? cnt : '0;

    fp32_mac u_mac (
        .a (patch_data),
        .b (filter_data),
        .c (acc),
        .y (mac_out)
    );

    // Pick the tag stage whose operand arrives now, and whether any older issue is still in flight.
    always_comb begin
        tag_exit = 1'b0;
        tag_pend = 1'b0;
        for (int i = 0; i <= RD_LAT_MAX; i++) begin
            if (i == RD_LAT) tag_exit = tag[i];
            if (i >= 1 && i < RD_LAT) tag_pend = tag_pend | tag[i];
        end
    end

    // Next state and next accumulator value.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        case (state)
            IDLE, FIN: begin
                state_nxt = IDLE;
                if (start) state_nxt = (vec_length == '0) ? FIN : ISSUE;
            end
            ISSUE: if (last) state_nxt = (RD_LAT == 0) ? FIN : DRAIN;
            DRAIN: if (!tag_pend) state_nxt = FIN;
            default: state_nxt = IDLE;
        endcase
        if (accept)        acc_nxt = FP32_ZERO;
        else if (tag_exit) acc_nxt = mac_out;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Counter, valid tags, accumulator and registered result/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            len    <= '0;
            cnt    <= '0;
            tag_q  <= '0;
            acc    <= FP32_ZERO;
            result <= FP32_ZERO;
            done   <= 1'b0;
        end else begin
            tag_q <= tag[RD_LAT_MAX-1:0];
            acc   <= acc_nxt;
            done  <= (state_nxt == FIN);
            if (state_nxt == FIN) result <= acc_nxt;
            if (accept) begin
                len <= vec_length;
                cnt <= '0;
            end else if (issue && !last) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule
